// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file writeback staging buffer.
//   DEPTH    : FIFO entries (power of two, >= 2)
//   DATA_W   : writeback data width
//   ADDR_W   : register index width
//   NUM_REGS : registers in the file (2**ADDR_W)
//   PTR_W    : FIFO index width; pointers carry one extra wrap bit (CNT_W)
//   wb_entry_t : one queued writeback {addr, data}
//   onehot_dec : register index -> per-register write select
package regfile_write_buffer_pkg;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] sel;
    sel    = '0;
    sel[a] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Bus bundle between a writeback producer / register file and the buffer.
//   in_valid/in_ready/in_addr/in_data : writeback request handshake
//   hold                              : register file busy, suppress drain
//   wr_data/wr_onehot/wr_general      : register file write port drive
//   rd_addr/fwd_hit/fwd_data          : read-port forwarding lookup
//   count                             : occupied entries
// master = environment side, slave = buffer side.
interface regfile_write_buffer_if;
  import regfile_write_buffer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_data;
  logic                hold;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] wr_onehot;
  logic                wr_general;
  logic [ADDR_W-1:0]   rd_addr;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic [CNT_W-1:0]    count;

  modport master (
    output in_valid, in_addr, in_data, hold, rd_addr,
    input  in_ready, wr_data, wr_onehot, wr_general, fwd_hit, fwd_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, hold, rd_addr,
    output in_ready, wr_data, wr_onehot, wr_general, fwd_hit, fwd_data, count
  );

endinterface

// File: rtl/regfile_write_buffer_wb_fwd_match.sv
// wb_fwd_match: combinational youngest-match search over queued entries.
//   i_entries : FIFO storage
//   i_head    : FIFO index of the oldest entry
//   i_count   : number of valid entries starting at i_head
//   i_rd_addr : register index being read
//   o_hit     : some valid entry targets i_rd_addr
//   o_data    : data of the youngest such entry, 0 when no hit
module regfile_write_buffer_wb_fwd_match
  import regfile_write_buffer_pkg::*;
(
  input  wb_entry_t         i_entries [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < i_count) &&
          (i_entries[PTR_W'(i_head + PTR_W'(k))].addr == i_rd_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[PTR_W'(i_head + PTR_W'(k))].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// Writeback staging buffer in front of the register file storage.
// Queues writeback requests in an in-order FIFO, drains at most one per cycle
// onto a shared data bus with a one-hot register select and global enable,
// and forwards still-queued data to a read port.
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-low reset
//   bus     : request / drain / forwarding signals (slave side)
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
(
  input logic                   i_clk,
  input logic                   i_reset,
  regfile_write_buffer_if.slave bus
);

  logic [CNT_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_tail;
  wb_entry_t         r_mem [DEPTH];

  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_ready;
  wb_entry_t         w_head_entry;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Extra wrap bit makes tail - head the exact occupancy, full included.
  assign w_count      = r_tail - r_head;
  assign w_ready      = i_reset && (w_count != CNT_W'(DEPTH));
  // Register 0 requests complete the handshake but are dropped here.
  assign w_push       = bus.in_valid && w_ready && (bus.in_addr != '0);
  assign w_pop        = i_reset && (w_count != '0) && !bus.hold;
  assign w_head_entry = r_mem[r_head[PTR_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + CNT_W'(1);
      if (w_pop)  r_head <= r_head + CNT_W'(1);
    end
  end

  // Storage carries no reset; validity comes from the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail[PTR_W-1:0]] <= '{addr: bus.in_addr, data: bus.in_data};
    end
  end

  regfile_write_buffer_wb_fwd_match u_fwd_match (
    .i_entries (r_mem),
    .i_head    (r_head[PTR_W-1:0]),
    .i_count   (w_count),
    .i_rd_addr (bus.rd_addr),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  always_comb begin
    bus.in_ready   = w_ready;
    bus.count      = w_count;
    bus.wr_general = 1'b0;
    bus.wr_onehot  = '0;
    bus.wr_data    = '0;
    bus.fwd_hit    = 1'b0;
    bus.fwd_data   = '0;
    if (w_pop) begin
      bus.wr_general = 1'b1;
      bus.wr_onehot  = onehot_dec(w_head_entry.addr);
      bus.wr_data    = w_head_entry.data;
    end
    // The head entry still counts as queued in the cycle it drains.
    if (i_reset && (bus.rd_addr != '0) && w_hit) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = w_fwd_data;
    end
  end

  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_reset)
    w_count <= CNT_W'(DEPTH));
  a_onehot: assert property (@(posedge i_clk) disable iff (!i_reset)
    $onehot0(bus.wr_onehot));

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Writeback staging buffer that sits directly upstream of the register file's per-register storage elements. It accepts writeback requests (destination index + 32-bit data), queues them in a small in-order FIFO, and drains at most one per cycle. Each drained entry is presented as a shared data bus, a one-hot per-register write select and a global write enable, which drive the register file's write ports. It also forwards still-queued data to read ports so reads never return stale values.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
DATA_W, 32, writeback data width
ADDR_W, 5, register index width
NUM_REGS, 32, registers in file (= 2**ADDR_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
in_valid  input  1  writeback request present
in_ready  output  1  buffer can accept request this cycle
in_addr  input  ADDR_W  destination register index
in_data  input  DATA_W  writeback value
hold  input  1  1 = register file busy, do not drain this cycle
wr_data  output  DATA_W  data to all register inputs
wr_onehot  output  NUM_REGS  one-hot specific write enable, bit i = register i
wr_general  output  1  global write enable
rd_addr  input  ADDR_W  read-port index for forwarding lookup
fwd_hit  output  1  a queued entry targets rd_addr
fwd_data  output  DATA_W  youngest queued value for rd_addr
count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0 at a clk edge): head/tail pointers, count and all entry valid bits cleared; entry contents need not be cleared. While reset is low: in_ready=0, wr_general=0, wr_onehot=0, wr_data=0, fwd_hit=0, fwd_data=0. A reset mid-drain discards all queued entries; nothing is written that cycle.
- in_ready = reset & (count != DEPTH). It does not depend on in_valid or hold. Full blocks acceptance even if a pop occurs that same cycle.
- Push: in_valid & in_ready & (in_addr != 0). The entry is written at tail, tail increments modulo DEPTH, and the entry is visible next cycle.
- Register 0 writes are handshaken (consumed) but never stored. count is unchanged.
- Pop: count != 0 & !hold. All drain outputs are combinational from the head entry:
  - wr_general = 1
  - wr_onehot = 1 << head.addr
  - wr_data = head.data
- The register file captures the entry on the same clk edge on which head increments modulo DEPTH. Latency from accepted push to register update is ≥1 edge; with an empty buffer and hold=0, the value is in the register after the second edge.
- When not popping: wr_general=0, wr_onehot=0, wr_data=0.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- Ordering is strict FIFO. Two queued writes to the same register drain in arrival order, so the final value is the last one.
- Forwarding (combinational):
  - fwd_hit = 1 iff rd_addr != 0 and some valid entry has addr == rd_addr.
  - fwd_data = data of the youngest such entry (closest to tail), otherwise 0.
  - The entry being popped this cycle still counts as queued.
  - The incoming in_* request is not forwarded.
- Pointers use one extra wrap bit. count = tail − head.
- No overflow or underflow is possible by construction. Assertions: count ≤ DEPTH, and wr_onehot is zero or exactly one-hot.

Decomposition:
- Shared package: entry struct {addr[ADDR_W], data[DATA_W]}, DEPTH/ADDR_W/NUM_REGS defaults, and a one-hot decode function.
- One natural sub-module: wb_fwd_match, the combinational youngest-match priority search over entries, given head, count and rd_addr.

Test Plan:
1. Reset low 2 cycles, then high → in_ready=1, count=0, wr_general=0, fwd_hit=0.
2. Push (addr=5, data=0xDEADBEEF), hold=0.
   - Next cycle: wr_general=1, wr_onehot=0x00000020, wr_data=0xDEADBEEF, fwd_hit=1 for rd_addr=5.
   - Cycle after: count=0.
3. hold=1, push 4 entries to addrs 1,2,3,4 → count=4, in_ready=0.
   - A 5th in_valid is not accepted.
   - Drop hold → drains 1,2,3,4 in order over 4 cycles, with wr_onehot 0x2, 0x4, 0x8, 0x10.
4. Push addr=0 data=0x1234 → in_ready=1 handshake completes, count stays 0, wr_general never asserts.
5. hold=1, push (7, 0x11) then (7, 0x22); rd_addr=7 → fwd_hit=1, fwd_data=0x22.
   - Release hold → wr_data 0x11 then 0x22 on consecutive cycles.
6. count=3 with hold=0, assert reset low during a drain → that edge: no write, count=0.
   - After release, wr_general stays 0 until a new push.
